// File: rtl/thiele_cpu_core.sv
// Multi-cycle Thiele machine core: XOR-algebra register ops, partition bookkeeping and mu ledger,
// with logic/Python engine handshakes. Define CHSH_TRIAL_EN to enable opcode 0x09 (CHSH_TRIAL).
module thiele_cpu_core #(
  parameter int NUM_MODULES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_data,
  output logic [31:0] pc,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] cert_addr,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain,
  output logic [31:0] mu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result
);

  localparam int MW = $clog2(NUM_MODULES);

  localparam logic [7:0] OP_PNEW     = 8'h00;
  localparam logic [7:0] OP_LASSERT  = 8'h03;
  localparam logic [7:0] OP_MDLACC   = 8'h05;
  localparam logic [7:0] OP_XFER     = 8'h07;
  localparam logic [7:0] OP_PYEXEC   = 8'h08;
  localparam logic [7:0] OP_CHSH     = 8'h09;
  localparam logic [7:0] OP_XOR_LOAD = 8'h0A;
  localparam logic [7:0] OP_XOR_ADD  = 8'h0B;
  localparam logic [7:0] OP_XOR_SWAP = 8'h0C;
  localparam logic [7:0] OP_XOR_RANK = 8'h0D;
  localparam logic [7:0] OP_EMIT     = 8'h0E;
  localparam logic [7:0] OP_HALT     = 8'hFF;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXECUTE = 4'd2,
    LOGIC   = 4'd3,
    PYTHON  = 4'd4
  } state_t;

  state_t state, state_next;

  logic [31:0] instr;
  logic [7:0]  op, fa, fb, cost;
  logic [31:0] reg_file [32];
  logic [31:0] data_mem [256];
  logic [7:0]  module_table [NUM_MODULES];

  logic [4:0] ra, rb;
  logic       running, pnew_ok, retire;
  logic       unused_rdata;

  assign ra      = fa[4:0];
  assign rb      = fb[4:0];
  assign running = (status == 32'd0);
  assign pnew_ok = (int'(fa) < NUM_MODULES);

  assign mem_addr     = '0;
  assign mem_wdata    = '0;
  assign mem_we       = 1'b0;
  assign mem_en       = 1'b0;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // HALT, unknown opcodes and a bad PNEW keep the machine parked in EXECUTE
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        if (running) begin
          case (op)
            OP_XOR_LOAD, OP_XOR_ADD, OP_XOR_SWAP, OP_XFER,
            OP_XOR_RANK, OP_EMIT, OP_MDLACC: begin
              state_next = FETCH;
              retire     = 1'b1;
            end
`ifdef CHSH_TRIAL_EN
            OP_CHSH: begin
              state_next = FETCH;
              retire     = 1'b1;
            end
`endif
            OP_PNEW: begin
              if (pnew_ok) begin
                state_next = FETCH;
                retire     = 1'b1;
              end
            end
            OP_LASSERT: state_next = LOGIC;
            OP_PYEXEC:  state_next = PYTHON;
            default: ;
          endcase
        end
      end
      LOGIC: begin
        if (logic_ack) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      PYTHON: begin
        if (py_ack) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= '0;
      status        <= '0;
      error_code    <= '0;
      cert_addr     <= '0;
      partition_ops <= '0;
      mdl_ops       <= '0;
      info_gain     <= '0;
      mu            <= '0;
      logic_req     <= 1'b0;
      logic_addr    <= '0;
      py_req        <= 1'b0;
      py_code_addr  <= '0;
      instr         <= '0;
      op            <= '0;
      fa            <= '0;
      fb            <= '0;
      cost          <= '0;
      for (int i = 0; i < 32; i++)          reg_file[i]     <= '0;
      for (int i = 0; i < 256; i++)         data_mem[i]     <= '0;
      for (int i = 0; i < NUM_MODULES; i++) module_table[i] <= '0;
    end else begin
      case (state)
        FETCH: instr <= instr_data;
        DECODE: begin
          op   <= instr[31:24];
          fa   <= instr[23:16];
          fb   <= instr[15:8];
          cost <= instr[7:0];
        end
        EXECUTE: begin
          if (running) begin
            case (op)
              OP_XOR_LOAD: reg_file[ra] <= data_mem[fb];
              OP_XOR_ADD:  reg_file[ra] <= reg_file[ra] ^ reg_file[rb];
              OP_XOR_SWAP: begin
                if (ra != rb) begin
                  reg_file[ra] <= reg_file[rb];
                  reg_file[rb] <= reg_file[ra];
                end
              end
              OP_XFER:     reg_file[ra] <= reg_file[rb];
              OP_XOR_RANK: reg_file[ra] <= 32'($countones(reg_file[rb]));
              OP_EMIT:     info_gain <= info_gain + {24'h0, fb};
              OP_MDLACC:   mdl_ops <= mdl_ops + 32'd1;
`ifdef CHSH_TRIAL_EN
              OP_CHSH: begin
                if ((fb[1] ^ fb[0]) == (fa[1] & fa[0]))
                  reg_file[31] <= reg_file[31] + 32'd1;
              end
`endif
              OP_PNEW: begin
                if (pnew_ok) begin
                  module_table[fa[MW-1:0]] <= fb;
                  partition_ops            <= partition_ops + 32'd1;
                end else begin
                  status     <= 32'd2;
                  error_code <= {24'h0, op};
                end
              end
              OP_LASSERT: begin
                logic_req  <= 1'b1;
                logic_addr <= {24'h0, fa};
              end
              OP_PYEXEC: begin
                py_req       <= 1'b1;
                py_code_addr <= {24'h0, fa};
              end
              // HALT is charged once; afterwards status blocks re-execution
              OP_HALT: begin
                status <= 32'd1;
                mu     <= mu + {24'h0, cost};
              end
              default: begin
                status     <= 32'd2;
                error_code <= {24'h0, op};
              end
            endcase
          end
        end
        LOGIC: begin
          if (logic_ack) begin
            cert_addr   <= logic_data;
            reg_file[0] <= logic_data;
            logic_req   <= 1'b0;
          end
        end
        PYTHON: begin
          if (py_ack) begin
            reg_file[0] <= py_result;
            py_req      <= 1'b0;
          end
        end
        default: ;
      endcase
      if (retire) begin
        mu <= mu + {24'h0, cost};
        pc <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_thiele_cpu_core.sv
// Self-checking bench for thiele_cpu_core: directed programs plus random programs
// compared against an instruction-level reference interpreter.
module tb_thiele_cpu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_data;
   logic [31:0] pc, status, error_code, cert_addr;
   logic [31:0] partition_ops, mdl_ops, info_gain, mu;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we, mem_en;
   logic [31:0] mem_rdata = 32'h0;
   logic        logic_req;
   logic [31:0] logic_addr;
   logic        logic_ack = 1'b0;
   logic [31:0] logic_data = 32'h0;
   logic        py_req;
   logic [31:0] py_code_addr;
   logic        py_ack = 1'b0;
   logic [31:0] py_result = 32'h0;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] rom [64];
   logic [31:0] eng_data [64];
   bit          eng_on = 1'b1;
   int          eng_delay = -1;

   logic [31:0] m_r [32];
   logic [7:0]  m_mt [64];
   logic [31:0] m_pc, m_status, m_err, m_cert, m_pops, m_mdl, m_ig, m_mu;

   thiele_cpu_core dut (
      .clk(clk), .rst(rst), .instr_data(instr_data), .pc(pc), .status(status),
      .error_code(error_code), .cert_addr(cert_addr), .partition_ops(partition_ops),
      .mdl_ops(mdl_ops), .info_gain(info_gain), .mu(mu), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en), .mem_rdata(mem_rdata),
      .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack),
      .logic_data(logic_data), .py_req(py_req), .py_code_addr(py_code_addr),
      .py_ack(py_ack), .py_result(py_result)
   );

   always #5 clk = ~clk;

   // The instruction ROM is combinational on the word address
   assign instr_data = rom[pc[7:2]];

   // Engine responder: after a programmable delay, pulse ack for one cycle with the word tied to the current pc
   initial begin
      int lwait;
      int pwait;
      lwait = -1;
      pwait = -1;
      forever begin
         @(negedge clk);
         if (eng_on) begin
            logic_ack = 1'b0;
            py_ack = 1'b0;
            if (logic_req) begin
               if (lwait < 0) lwait = (eng_delay >= 0) ? eng_delay : int'($urandom_range(0, 3));
               if (lwait == 0) begin
                  logic_ack = 1'b1;
                  logic_data = eng_data[pc[7:2]];
                  lwait = -1;
               end else lwait--;
            end else lwait = -1;
            if (py_req) begin
               if (pwait < 0) pwait = (eng_delay >= 0) ? eng_delay : int'($urandom_range(0, 3));
               if (pwait == 0) begin
                  py_ack = 1'b1;
                  py_result = eng_data[pc[7:2]];
                  pwait = -1;
               end else pwait--;
            end else pwait = -1;
         end
      end
   end

   function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
      return {op, a, b, c};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < 64; i++) rom[i] = 32'hFF00_0000;
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitHalt(input string tag);
      int k;
      k = 0;
      while (status == 32'd0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      checkOutput({tag, "_stopped"}, {31'h0, status != 32'd0}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic waitReq(input string tag, input bit py);
      int k;
      k = 0;
      while (!(py ? py_req : logic_req) && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput({tag, "_req_seen"}, {31'h0, py ? py_req : logic_req}, 32'd1);
   endtask

   // Reference interpreter: one instruction per step, straight from the ISA rules
   task automatic modelRun();
      logic [31:0] w, tmp;
      logic [7:0]  op, a, b, c;
      int          idx, cnt;
      bit          ret;
      for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
      for (int i = 0; i < 64; i++) m_mt[i] = 8'h0;
      m_pc = 0; m_status = 0; m_err = 0; m_cert = 0;
      m_pops = 0; m_mdl = 0; m_ig = 0; m_mu = 0;
      for (int step = 0; step < 200 && m_status == 0; step++) begin
         idx = int'(m_pc[7:2]);
         w = rom[idx];
         op = w[31:24]; a = w[23:16]; b = w[15:8]; c = w[7:0];
         ret = 1'b1;
         case (op)
            8'h0A: m_r[a % 32] = 32'h0;
            8'h0B: m_r[a % 32] = m_r[a % 32] ^ m_r[b % 32];
            8'h0C: begin
               tmp = m_r[a % 32];
               m_r[a % 32] = m_r[b % 32];
               m_r[b % 32] = tmp;
            end
            8'h07: m_r[a % 32] = m_r[b % 32];
            8'h0D: begin
               cnt = 0;
               tmp = m_r[b % 32];
               for (int k = 0; k < 32; k++) if (tmp[k]) cnt++;
               m_r[a % 32] = cnt;
            end
            8'h0E: m_ig = m_ig + b;
            8'h00: begin
               if (a < 64) begin
                  m_mt[a] = b;
                  m_pops++;
               end else begin
                  m_status = 2; m_err = op; ret = 1'b0;
               end
            end
            8'h05: m_mdl++;
            8'h03: begin
               m_r[0] = eng_data[idx];
               m_cert = eng_data[idx];
            end
            8'h08: m_r[0] = eng_data[idx];
            8'hFF: begin
               m_status = 1; m_mu = m_mu + c; ret = 1'b0;
            end
`ifdef CHSH_TRIAL_EN
            8'h09: if ((b[1] ^ b[0]) == (a[1] & a[0])) m_r[31] = m_r[31] + 1;
`endif
            default: begin
               m_status = 2; m_err = op; ret = 1'b0;
            end
         endcase
         if (ret) begin
            m_mu = m_mu + c;
            m_pc = m_pc + 4;
         end
      end
   endtask

   task automatic compareAll(input string tag);
      modelRun();
      checkOutput({tag, "_pc"}, pc, m_pc);
      checkOutput({tag, "_status"}, status, m_status);
      checkOutput({tag, "_error_code"}, error_code, m_err);
      checkOutput({tag, "_mu"}, mu, m_mu);
      checkOutput({tag, "_info_gain"}, info_gain, m_ig);
      checkOutput({tag, "_partition_ops"}, partition_ops, m_pops);
      checkOutput({tag, "_mdl_ops"}, mdl_ops, m_mdl);
      checkOutput({tag, "_cert_addr"}, cert_addr, m_cert);
      checkOutput({tag, "_logic_req"}, {31'h0, logic_req}, 32'd0);
      checkOutput({tag, "_py_req"}, {31'h0, py_req}, 32'd0);
      for (int i = 0; i < 32; i++)
         checkOutput($sformatf("%s_r%0d", tag, i), dut.reg_file[i], m_r[i]);
      for (int i = 0; i < 64; i++)
         checkOutput($sformatf("%s_mt%0d", tag, i), {24'h0, dut.module_table[i]}, {24'h0, m_mt[i]});
   endtask

   task automatic applyStimulus(input int len);
      logic [7:0] opl [12];
      logic [7:0] op, a;
      int r;
      opl = '{8'h0A, 8'h0B, 8'h0C, 8'h07, 8'h0D, 8'h0E, 8'h00, 8'h05, 8'h03, 8'h08, 8'h08, 8'h07};
      clearRom();
      for (int i = 0; i < 64; i++) eng_data[i] = $urandom;
      for (int i = 0; i < len - 1; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3)      op = 8'h42;
         else if (r < 6) op = 8'h09;
         else            op = opl[$urandom_range(0, 11)];
         a = (op == 8'h00) ? 8'($urandom_range(0, 70)) : 8'($urandom);
         rom[i] = ins(op, a, 8'($urandom), 8'($urandom));
      end
      rom[len - 1] = ins(8'hFF, 8'h0, 8'h0, 8'($urandom));
   endtask

   initial begin
      // Reset values
      clearRom();
      repeat (3) @(negedge clk);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_status", status, 32'h0);
      checkOutput("rst_mu", mu, 32'h0);
      checkOutput("rst_info_gain", info_gain, 32'h0);
      checkOutput("rst_logic_req", {31'h0, logic_req}, 32'h0);
      checkOutput("rst_py_req", {31'h0, py_req}, 32'h0);
      checkOutput("rst_mem_bus", {mem_addr[30:0] | mem_wdata[30:0], mem_we | mem_en}, 32'h0);
      rst = 1'b0;

      // XOR algebra program; registers seeded through the Python engine
      clearRom();
      eng_delay = 1;
      eng_data[0] = 32'h03; eng_data[2] = 32'h22; eng_data[4] = 32'h12; eng_data[6] = 32'h29;
      rom[0]  = ins(8'h08, 8'h00, 8'h00, 8'h00);
      rom[1]  = ins(8'h07, 8'h03, 8'h00, 8'h00);
      rom[2]  = ins(8'h08, 8'h00, 8'h00, 8'h00);
      rom[3]  = ins(8'h07, 8'h02, 8'h00, 8'h00);
      rom[4]  = ins(8'h08, 8'h00, 8'h00, 8'h00);
      rom[5]  = ins(8'h07, 8'h01, 8'h00, 8'h00);
      rom[6]  = ins(8'h08, 8'h00, 8'h00, 8'h00);
      rom[7]  = ins(8'h0B, 8'h03, 8'h00, 8'h00);
      rom[8]  = ins(8'h0B, 8'h03, 8'h01, 8'h00);
      rom[9]  = ins(8'h0C, 8'h00, 8'h03, 8'h00);
      rom[10] = ins(8'h07, 8'h04, 8'h02, 8'h00);
      rom[11] = ins(8'h0D, 8'h05, 8'h04, 8'h00);
      rom[12] = ins(8'h0E, 8'h00, 8'h04, 8'h00);
      rom[13] = ins(8'h0A, 8'h02, 8'h05, 8'h00);
      doReset();
      waitHalt("xor");
      checkOutput("xor_r0_const", dut.reg_file[0], 32'h38);
      checkOutput("xor_r3_const", dut.reg_file[3], 32'h29);
      checkOutput("xor_r4_const", dut.reg_file[4], 32'h22);
      checkOutput("xor_r5_const", dut.reg_file[5], 32'h2);
      checkOutput("xor_info_gain_const", info_gain, 32'h4);
      checkOutput("xor_pc_const", pc, 32'h38);
      compareAll("xor");

      // Cost accounting and three-cycle plain ops
      clearRom();
      rom[0] = ins(8'h05, 8'h00, 8'h00, 8'h03);
      rom[1] = ins(8'h0E, 8'h00, 8'h00, 8'h05);
      doReset();
      repeat (3) @(negedge clk);
      checkOutput("cost_pc_1", pc, 32'h4);
      checkOutput("cost_mu_1", mu, 32'h3);
      repeat (3) @(negedge clk);
      checkOutput("cost_pc_2", pc, 32'h8);
      checkOutput("cost_mu_2", mu, 32'h8);
      waitHalt("cost");
      checkOutput("cost_mu_halt", mu, 32'h8);
      checkOutput("cost_status", status, 32'h1);

      // LASSERT handshake with a two-cycle engine delay
      clearRom();
      eng_delay = 2;
      eng_data[0] = 32'hABCD1234;
      rom[0] = ins(8'h03, 8'h07, 8'h00, 8'h02);
      doReset();
      waitReq("lassert", 1'b0);
      checkOutput("lassert_addr", logic_addr, 32'h7);
      @(negedge clk);
      checkOutput("lassert_req_held", {31'h0, logic_req}, 32'd1);
      waitHalt("lassert");
      checkOutput("lassert_cert", cert_addr, 32'hABCD1234);
      checkOutput("lassert_r0", dut.reg_file[0], 32'hABCD1234);
      compareAll("lassert");

      // PYEXEC handshake
      clearRom();
      eng_data[0] = 32'h12345678;
      rom[0] = ins(8'h08, 8'h09, 8'h00, 8'h01);
      doReset();
      waitReq("pyexec", 1'b1);
      checkOutput("pyexec_addr", py_code_addr, 32'h9);
      waitHalt("pyexec");
      checkOutput("pyexec_r0", dut.reg_file[0], 32'h12345678);
      checkOutput("pyexec_req_low", {31'h0, py_req}, 32'd0);
      eng_delay = -1;

      // Partition ops followed by an unknown opcode
      clearRom();
      rom[0] = ins(8'h00, 8'h02, 8'h05, 8'h01);
      rom[1] = ins(8'h05, 8'h00, 8'h00, 8'h01);
      rom[2] = ins(8'h42, 8'h00, 8'h00, 8'h01);
      doReset();
      waitHalt("pnew");
      checkOutput("pnew_mt2", {24'h0, dut.module_table[2]}, 32'h5);
      checkOutput("pnew_status", status, 32'h2);
      checkOutput("pnew_error_code", error_code, 32'h42);
      compareAll("pnew");

      // Acks arriving while nothing is waiting are ignored
      eng_on = 1'b0;
      logic_ack = 1'b1; py_ack = 1'b1;
      logic_data = 32'hDEADBEEF; py_result = 32'hCAFEF00D;
      clearRom();
      rom[0] = ins(8'h05, 8'h00, 8'h00, 8'h00);
      doReset();
      waitHalt("stray");
      checkOutput("stray_cert", cert_addr, 32'h0);
      checkOutput("stray_r0", dut.reg_file[0], 32'h0);
      checkOutput("stray_mdl", mdl_ops, 32'h1);
      logic_ack = 1'b0; py_ack = 1'b0;

      // Reset in the middle of a LOGIC wait
      clearRom();
      rom[0] = ins(8'h05, 8'h00, 8'h00, 8'h07);
      rom[1] = ins(8'h03, 8'h03, 8'h00, 8'h00);
      doReset();
      waitReq("midrst", 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("midrst_req_waiting", {31'h0, logic_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_req", {31'h0, logic_req}, 32'd0);
      checkOutput("midrst_pc", pc, 32'h0);
      checkOutput("midrst_mu", mu, 32'h0);
      checkOutput("midrst_mdl", mdl_ops, 32'h0);
      rst = 1'b0;
      eng_on = 1'b1;

      // Random programs against the reference interpreter
      for (int p = 0; p < 12; p++) begin
         applyStimulus(int'($urandom_range(12, 30)));
         doReset();
         waitHalt($sformatf("rnd%0d", p));
         compareAll($sformatf("rnd%0d", p));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
